// File: rtl/trng_vn_packer.sv
// trng_vn_packer: von Neumann debiaser, MSB-first byte packer and repetition-count
// health test behind a one-entry valid/ready output register.
// Optional build macro TRNG_VN_BYPASS_EN adds the vn_bypass input, which feeds every
// accepted raw sample straight into the packer.
module trng_vn_packer #(
   parameter int unsigned RCT_CUTOFF = 32,
   parameter int unsigned OVF_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,        // active-high despite the name
   input  logic             enable,
   input  logic             raw_bit,
   input  logic             raw_valid,
   input  logic             health_clr,
   input  logic             out_ready,
`ifdef TRNG_VN_BYPASS_EN
   input  logic             vn_bypass,
`endif
   output logic [7:0]       out_byte,
   output logic             out_valid,
   output logic             health_fail,
   output logic [OVF_W-1:0] ovf_cnt
);

   typedef enum logic {StEmpty, StHalf} pair_state_e;

   localparam logic [7:0] CutoffVal = 8'(RCT_CUTOFF);

   pair_state_e      pair_q, pair_d;
   logic             first_q, first_d;
   logic [6:0]       shift_q, shift_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       run_cnt_q, run_cnt_d;
   logic             last_bit_q, last_bit_d;
   logic [7:0]       out_byte_q, out_byte_d;
   logic             out_valid_q, out_valid_d;
   logic             health_fail_q, health_fail_d;
   logic [OVF_W-1:0] ovf_q, ovf_d;

   logic accepted, bypass, trip, block, emit, emit_bit, completed;

`ifdef TRNG_VN_BYPASS_EN
   assign bypass = vn_bypass;
`else
   assign bypass = 1'b0;
`endif

   assign accepted = raw_valid & enable;

   // Next-state: health test, pair FSM, packer and output register
   always_comb begin
      pair_d        = pair_q;
      first_d       = first_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      run_cnt_d     = run_cnt_q;
      last_bit_d    = last_bit_q;
      out_byte_d    = out_byte_q;
      out_valid_d   = out_valid_q;
      health_fail_d = health_fail_q;
      ovf_d         = ovf_q;
      trip          = 1'b0;
      emit          = 1'b0;
      emit_bit      = 1'b0;
      completed     = 1'b0;

      // Repetition count; run_cnt of 0 marks "no sample since reset/clear"
      if (health_clr) begin
         run_cnt_d     = '0;
         health_fail_d = 1'b0;
      end else if (accepted) begin
         if (run_cnt_q == 8'd0 || raw_bit != last_bit_q) begin
            run_cnt_d = 8'd1;
         end else if (run_cnt_q < CutoffVal) begin
            run_cnt_d = run_cnt_q + 8'd1;
         end
         last_bit_d    = raw_bit;
         trip          = (run_cnt_d == CutoffVal);
         health_fail_d = health_fail_q | trip;
      end

      // A trip blocks output on the same edge it is flagged
      block = ~health_clr & (health_fail_q | trip);

      if (health_clr || block) begin
         pair_d    = StEmpty;
         shift_d   = '0;
         bit_cnt_d = '0;
      end else if (!enable) begin
         pair_d = StEmpty;
      end else if (raw_valid) begin
         if (bypass) begin
            pair_d   = StEmpty;
            emit     = 1'b1;
            emit_bit = raw_bit;
         end else begin
            unique case (pair_q)
               StEmpty: begin
                  first_d = raw_bit;
                  pair_d  = StHalf;
               end
               StHalf: begin
                  pair_d   = StEmpty;
                  emit     = (first_q != raw_bit);
                  emit_bit = first_q;
               end
               default: pair_d = StEmpty;
            endcase
         end
      end

      if (emit) begin
         shift_d   = {shift_q[5:0], emit_bit};
         bit_cnt_d = bit_cnt_q + 3'd1;
         completed = (bit_cnt_q == 3'd7);
      end

      if (block) begin
         out_valid_d = 1'b0;
      end else if (completed) begin
         if (!out_valid_q || out_ready) begin
            out_byte_d  = {shift_q, emit_bit};
            out_valid_d = 1'b1;
         end else if (ovf_q != '1) begin
            ovf_d = ovf_q + 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous, top-priority reset
   always_ff @(posedge clk) begin
      if (rst_n) begin
         pair_q        <= StEmpty;
         first_q       <= 1'b0;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         run_cnt_q     <= '0;
         last_bit_q    <= 1'b0;
         out_byte_q    <= '0;
         out_valid_q   <= 1'b0;
         health_fail_q <= 1'b0;
         ovf_q         <= '0;
      end else begin
         pair_q        <= pair_d;
         first_q       <= first_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         run_cnt_q     <= run_cnt_d;
         last_bit_q    <= last_bit_d;
         out_byte_q    <= out_byte_d;
         out_valid_q   <= out_valid_d;
         health_fail_q <= health_fail_d;
         ovf_q         <= ovf_d;
      end
   end

   assign out_byte    = out_byte_q;
   assign out_valid   = out_valid_q;
   assign health_fail = health_fail_q;
   assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_trng_vn_packer.sv
// Bench for trng_vn_packer: directed scenarios plus random traffic, checked by a
// scoreboard against a bit-queue reference model. Build with TRNG_VN_BYPASS_EN to
// also exercise the bypass path.
module tb_trng_vn_packer;

   localparam int unsigned CUT   = 32;
   localparam int unsigned OVF_W = 8;

   logic             clk = 1'b0;
   logic             rst_n, enable, raw_bit, raw_valid, health_clr, out_ready;
   logic             vn_bypass = 1'b0;
   logic [7:0]       out_byte;
   logic             out_valid, health_fail;
   logic [OVF_W-1:0] ovf_cnt;

   trng_vn_packer #(.RCT_CUTOFF(CUT), .OVF_W(OVF_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .raw_bit     (raw_bit),
      .raw_valid   (raw_valid),
      .health_clr  (health_clr),
      .out_ready   (out_ready),
`ifdef TRNG_VN_BYPASS_EN
      .vn_bypass   (vn_bypass),
`endif
      .out_byte    (out_byte),
      .out_valid   (out_valid),
      .health_fail (health_fail),
      .ovf_cnt     (ovf_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model state
   bit         m_half, m_first, m_last, m_fail, m_valid;
   int         m_run, m_ovf;
   bit         m_bits[$];
   logic [7:0] exp_q[$];
   bit         started = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge
   task automatic model_edge();
      bit         trip;
      logic [7:0] b;
      if (rst_n) begin
         m_half = 0; m_first = 0; m_last = 0; m_fail = 0; m_valid = 0;
         m_run = 0; m_ovf = 0; m_bits.delete();
         return;
      end
      if (health_clr) begin
         m_fail = 0; m_run = 0; m_half = 0; m_bits.delete();
         if (m_valid && out_ready) m_valid = 0;
         return;
      end
      trip = 0;
      if (raw_valid && enable) begin
         if (m_run == 0 || raw_bit != m_last) m_run = 1;
         else if (m_run < int'(CUT)) m_run++;
         m_last = raw_bit;
         if (m_run == int'(CUT)) trip = 1;
      end
      if (m_fail || trip) begin
         m_fail = 1; m_half = 0; m_bits.delete(); m_valid = 0;
         return;
      end
      if (!enable) begin
         m_half = 0;
      end else if (raw_valid) begin
         if (vn_bypass) begin
            m_half = 0;
            m_bits.push_back(raw_bit);
         end else if (!m_half) begin
            m_first = raw_bit;
            m_half  = 1;
         end else begin
            m_half = 0;
            if (m_first != raw_bit) m_bits.push_back(m_first);
         end
      end
      if (m_bits.size() == 8) begin
         b = 8'h00;
         foreach (m_bits[i]) b = {b[6:0], m_bits[i]};
         m_bits.delete();
         if (!m_valid || out_ready) begin
            m_valid = 1;
            exp_q.push_back(b);
         end else if (m_ovf < (1 << OVF_W) - 1) begin
            m_ovf++;
         end
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
   endtask

   task automatic drive(input bit rst, input bit en, input bit rv, input bit rb,
                        input bit clr, input bit rdy);
      rst_n = rst; enable = en; raw_valid = rv; raw_bit = rb;
      health_clr = clr; out_ready = rdy;
      @(posedge clk);
      model_edge();
      started = 1'b1;
      #1;
   endtask

   task automatic idle(input bit rdy);
      drive(0, 1, 0, 0, 0, rdy);
   endtask

   task automatic samp(input bit b, input bit rdy);
      drive(0, 1, 1, b, 0, rdy);
   endtask

   task automatic send_bit(input bit d, input bit rdy);
      if (d) begin samp(1, rdy); samp(0, rdy); end
      else begin samp(0, rdy); samp(1, rdy); end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rdy);
      for (int i = 7; i >= 0; i--) send_bit(b[i], rdy);
   endtask

   // Monitor: every loaded byte is presented exactly once and popped here
   bit         p_valid = 0, p_ready = 0;
   logic [7:0] p_byte = 8'h00;
   always @(negedge clk) begin
      if (started) begin
         check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
         check("health_fail", {31'b0, health_fail}, {31'b0, m_fail});
         check("ovf_cnt", {24'b0, ovf_cnt}, m_ovf);
         if (out_valid && (!p_valid || p_ready)) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", out_byte, $time);
            end else begin
               check("out_byte", {24'b0, out_byte}, {24'b0, exp_q.pop_front()});
            end
         end
         if (p_valid && !p_ready && out_valid)
            check("hold_stable", {24'b0, out_byte}, {24'b0, p_byte});
         p_valid = out_valid;
         p_ready = out_ready;
         p_byte  = out_byte;
      end
   end

   bit seq[24] = '{0,1, 0,0, 1,0, 1,1, 1,0, 0,0, 0,1, 1,1, 0,1, 0,1, 1,0, 1,0};

   initial begin
      bit stuck, sb, rst, en, rv, rb, clr, rdy;
      logic [7:0] tmp;

      // Reset
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      check("rst_out_byte", {24'b0, out_byte}, 32'h00);
      check("rst_out_valid", {31'b0, out_valid}, 32'h0);
      check("rst_health_fail", {31'b0, health_fail}, 32'h0);
      check("rst_ovf_cnt", {24'b0, ovf_cnt}, 32'h0);

      // 0x63 from 01,10,10,01,01,01,10,10; last sample held back to check latency
      tmp = 8'h63;
      for (int i = 7; i >= 1; i--) send_bit(tmp[i], 1);
      samp(1, 1);
      check("t1_not_yet", {31'b0, out_valid}, 32'h0);
      samp(0, 1);
      check("t1_valid", {31'b0, out_valid}, 32'h1);
      check("t1_byte", {24'b0, out_byte}, 32'h63);
      check("t1_ovf", {24'b0, ovf_cnt}, 32'h0);

      // 00/11 pairs interleaved with the 0x63 stream are discarded
      foreach (seq[i]) samp(seq[i], 1);
      check("t2_byte", {24'b0, out_byte}, 32'h63);
      check("t2_valid", {31'b0, out_valid}, 32'h1);
      idle(1);

      // Backpressure: first byte held, next two dropped
      send_byte(8'hA5, 0);
      send_byte(8'h3C, 0);
      send_byte(8'hFF, 0);
      check("t3_byte", {24'b0, out_byte}, 32'hA5);
      check("t3_valid", {31'b0, out_valid}, 32'h1);
      check("t3_ovf", {24'b0, ovf_cnt}, 32'h2);
      idle(1);
      check("t3_drain", {31'b0, out_valid}, 32'h0);

      // Health trip on the 32nd consecutive 1 with a byte held
      send_byte(8'h81, 0);
      drive(0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 31; i++) samp(1, 0);
      check("t4_pre_fail", {31'b0, health_fail}, 32'h0);
      check("t4_pre_valid", {31'b0, out_valid}, 32'h1);
      samp(1, 0);
      check("t4_fail", {31'b0, health_fail}, 32'h1);
      check("t4_valid_forced", {31'b0, out_valid}, 32'h0);
      drive(0, 1, 0, 0, 1, 1);
      check("t4_clr", {31'b0, health_fail}, 32'h0);
      send_byte(8'h63, 1);
      check("t4_recover_valid", {31'b0, out_valid}, 32'h1);
      check("t4_recover_byte", {24'b0, out_byte}, 32'h63);
      idle(1);

      // Enable drop loses the half pair: 1011001 + half(1) + gap + pair 01 -> 0xB2
      tmp = 8'hB2;
      for (int i = 7; i >= 1; i--) send_bit(tmp[i], 1);
      samp(1, 1);
      drive(0, 0, 1, 0, 0, 1);
      send_bit(0, 1);
      check("t5_valid", {31'b0, out_valid}, 32'h1);
      check("t5_byte", {24'b0, out_byte}, 32'hB2);
      idle(1);

      // Reset mid-byte with a byte held
      send_byte(8'h42, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
      drive(1, 1, 1, 1, 0, 0);
      check("t6_byte", {24'b0, out_byte}, 32'h00);
      check("t6_valid", {31'b0, out_valid}, 32'h0);
      check("t6_fail", {31'b0, health_fail}, 32'h0);
      check("t6_ovf", {24'b0, ovf_cnt}, 32'h0);
      tmp = 8'hD2;
      for (int i = 7; i >= 4; i--) send_bit(tmp[i], 1);
      check("t6_no_byte", {31'b0, out_valid}, 32'h0);
      for (int i = 3; i >= 0; i--) send_bit(tmp[i], 1);
      check("t6_byte_after", {24'b0, out_byte}, 32'hD2);
      idle(1);

`ifdef TRNG_VN_BYPASS_EN
      // Bypass: raw bits go straight to the packer
      vn_bypass = 1'b1;
      tmp = 8'hA5;
      for (int i = 7; i >= 0; i--) samp(tmp[i], 1);
      check("t7_valid", {31'b0, out_valid}, 32'h1);
      check("t7_byte", {24'b0, out_byte}, 32'hA5);
      vn_bypass = 1'b0;
      idle(1);
`endif

      // Random traffic
      stuck = 0; sb = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) begin
            stuck = ($urandom % 3 == 0);
            sb    = 1'($urandom % 2);
`ifdef TRNG_VN_BYPASS_EN
            vn_bypass = ($urandom % 3 == 0);
`endif
         end
         rst = ($urandom % 1500 == 0);
         en  = ($urandom % 10 != 0);
         rv  = ($urandom % 5 != 0);
         rb  = stuck ? sb : 1'($urandom % 2);
         clr = ($urandom % 300 == 0) || (m_fail && $urandom % 40 == 0);
         rdy = ($urandom % 3 != 0);
         drive(rst, en, rv, rb, clr, rdy);
      end

      idle(1);
      @(negedge clk);
      #1;
      check("scoreboard_empty", exp_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trng_vn_packer.md
Name: trng_vn_packer

Overview:
- Downstream stage of the ring-oscillator XOR sampler. Consumes its registered raw XOR bit, one candidate bit per clk.
- Applies a von Neumann debiaser and packs the debiased bits MSB-first into bytes.
- Presents bytes on a valid/ready interface to the readout logic.
- Runs a repetition-count health test on the raw stream and blocks output when the test fails.

Parameters:
- RCT_CUTOFF, 32: raw run length that trips the health test; legal range 2..255.
- OVF_W, 8: width of the saturating overflow counter.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous, active-high reset. The name follows the codebase; the polarity is high. Asserted (1) clears all state at the next posedge clk.
- enable  in  1  1 = accept raw bits; 0 = hold.
- raw_bit  in  1  raw XOR sample from the upstream sampler.
- raw_valid  in  1  raw_bit is a new sample this cycle.
- health_clr  in  1  one-cycle pulse that clears health_fail and the run counter.
- out_ready  in  1  consumer accepts out_byte this cycle.
- out_byte  out  8  packed debiased byte.
- out_valid  out  1  out_byte holds an unconsumed byte.
- health_fail  out  1  sticky repetition-count failure.
- ovf_cnt  out  OVF_W  number of bytes dropped because the holding register was full; saturates.

Behaviour:
- All updates occur on posedge clk. The rst_n check is synchronous and has top priority.
- Reset values: out_byte=0x00, out_valid=0, health_fail=0, ovf_cnt=0. Internally: pair FSM=EMPTY, bit_cnt=0, shift=0, run_cnt=0, last_bit=0.
- A sample is "accepted" when raw_valid=1 and enable=1.

Pair FSM:
- EMPTY: on an accepted sample, store first=raw_bit and go to HALF.
- HALF: on an accepted sample, go to EMPTY and apply the debiaser rule to the pair (first, raw_bit):
  - 01 emits debiased bit 0.
  - 10 emits debiased bit 1.
  - 00 and 11 emit nothing.
- enable=0 forces the FSM to EMPTY, discarding any half pair. Packer, run counter and output state hold.

Packer:
- Each emitted bit does shift <= {shift[6:0], bit} and bit_cnt+1.
- When the 8th bit is emitted, the completed byte {shift[6:0], bit} is offered to the output register in the same edge, and bit_cnt wraps to 0.

Output register:
- If out_valid=0, or out_valid=1 with out_ready=1: load the completed byte and set out_valid=1. The byte is visible the cycle after the 8th accepted-pair edge.
- If out_valid=1 and out_ready=0: drop the completed byte and increment ovf_cnt, saturating at all-ones. The held byte is unchanged.
- With no completed byte: out_valid=1 and out_ready=1 clears out_valid; out_byte keeps its last value.
- out_byte never changes while out_valid=1 and out_ready=0.

Repetition-count test:
- Operates on accepted raw samples, independent of the pair FSM.
- First sample after reset or health_clr: run_cnt=1.
- Later samples: run_cnt+1 if raw_bit==last_bit, else run_cnt=1. Saturates at RCT_CUTOFF.
- When run_cnt would reach RCT_CUTOFF, health_fail <= 1 on that edge.

While health_fail=1:
- out_valid is forced to 0 and any held byte is discarded.
- Completed bytes are neither loaded nor counted as overflow.
- Pair FSM and packer are cleared to EMPTY/0.

health_clr=1:
- Clears health_fail and run_cnt and restarts the pair FSM and packer.
- Takes priority over a same-edge trip.

Reset mid-byte: partial byte and half pair are discarded; no byte is emitted.

Optional Feature:
- Macro TRNG_VN_BYPASS_EN.
- Defined: adds input port vn_bypass (1 bit). When vn_bypass=1, every accepted raw sample is pushed straight into the packer (1 bit per sample) and the pair FSM is held in EMPTY. The health test and output handshake are unchanged.
- Undefined: no vn_bypass port; the debiaser is always active.

Test Plan:
- Reset, then feed 16 accepted samples 01,10,10,01,01,01,10,10 with out_ready=1 → out_valid rises one cycle after the 16th sample, out_byte=0x63; ovf_cnt=0.
- Feed pairs 00,11,00,11 interleaved with the 0x63 stream → 00/11 pairs are discarded and out_byte is still 0x63.
- Hold out_ready=0 and produce three bytes 0xA5, 0x3C, 0xFF → out_byte=0xA5 stays stable with out_valid=1 and ovf_cnt=2. Raise out_ready for one cycle → out_valid=0.
- With RCT_CUTOFF=32, feed 32 consecutive accepted 1s → health_fail=1 on the 32nd edge and out_valid=0. Pulse health_clr → health_fail=0, and a fresh 16-sample stream yields a byte.
- Feed 7 pairs, drop enable for one cycle after a half pair, then supply the remaining bits → the half pair is lost and the byte assembles from the 7 prior bits plus the next full pair. Separately, assert rst_n mid-byte → no byte is emitted and all outputs are zero.
- With TRNG_VN_BYPASS_EN defined and vn_bypass=1, feed raw bits 1,0,1,0,0,1,0,1 → out_byte=0xA5 one cycle after the 8th sample.
